// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: FSM states and the buffered
// instruction/PC entry.
package ifq_pkg;

    localparam int IFQ_N_INSTR = 16;
    localparam int IFQ_ADDR_W  = 8;

    typedef enum logic {
        FETCH,
        FLUSH
    } ifq_state_t;

    typedef struct packed {
        logic [IFQ_N_INSTR-1:0] instr;
        logic [IFQ_ADDR_W-1:0]  pc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched instruction/PC entries with synchronous clear.
// The head output keeps showing the last entry presented while the buffer is empty.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  ifq_entry_t    wdata_i,
    output ifq_entry_t    head_o,
    output logic [CW-1:0] count_o
);

    ifq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [PW-1:0] holdPtr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] dispIdx;
    logic          doPush;
    logic          doPop;

    assign doPush  = push_i && !clear_i;
    assign doPop   = pop_i && (count_q != '0) && !clear_i;
    // An empty buffer keeps pointing at whatever was last shown.
    assign dispIdx = (count_q != '0) ? rdPtr_q : holdPtr_q;
    assign head_o  = mem_q[dispIdx];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            holdPtr_q <= '0;
            count_q   <= '0;
        end else begin
            holdPtr_q <= dispIdx;
            if (clear_i) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
            end else begin
                if (doPush) begin
                    mem_q[wrPtr_q] <= wdata_i;
                    wrPtr_q        <= wrPtr_q + PW'(1);
                end
                if (doPop) begin
                    rdPtr_q <= rdPtr_q + PW'(1);
                end
                count_q <= count_q + CW'(doPush) - CW'(doPop);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with a credit-limited queue toward the decoder.
// Define IFQ_STALL_COUNT_EN to add the 16-bit saturating stall_cnt output.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int              N_INSTR  = IFQ_N_INSTR,
    parameter int              ADDR_W   = IFQ_ADDR_W,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [N_INSTR-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    output logic [N_INSTR-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef IFQ_STALL_COUNT_EN
    output logic [15:0]        stall_cnt,
`endif
    input  logic               out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
    logic [ADDR_W-1:0] retPc_q, retPc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     stale_q, stale_d;
    logic              started_q;
    logic [CW-1:0]     fifoCount;
    logic              reqAllowed;
    logic              granted;
    logic              rspValid;
    logic              doPush;
    logic              doPop;
    ifq_entry_t        pushEntry;
    ifq_entry_t        headEntry;

    // Requests only go out when every in-flight response is guaranteed a slot.
    assign reqAllowed = started_q && (state_q == FETCH) &&
                        (({1'b0, fifoCount} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH));
    assign imem_req   = reqAllowed && !redirect_valid;
    assign granted    = reqAllowed && imem_gnt;
    assign rspValid   = imem_rvalid && (outstanding_q != '0);
    assign doPush     = rspValid && (stale_q == '0) && !redirect_valid;
    assign doPop      = out_valid && out_ready;
    assign imem_addr  = fetchPc_q;

    assign pushEntry.instr = imem_rdata;
    assign pushEntry.pc    = retPc_q;
    assign out_valid       = (fifoCount != '0);
    assign out_instr       = headEntry.instr;
    assign out_pc          = headEntry.pc;

    // A redirect wins over everything; a grant taken in that cycle becomes stale.
    always_comb begin
        outstanding_d = outstanding_q + CW'(granted) - CW'(rspValid);
        fetchPc_d     = granted ? fetchPc_q + ADDR_W'(1) : fetchPc_q;
        retPc_d       = doPush ? retPc_q + ADDR_W'(1) : retPc_q;
        stale_d       = (rspValid && (stale_q != '0)) ? stale_q - CW'(1) : stale_q;
        state_d       = state_q;
        if ((state_q == FLUSH) && (stale_q == '0)) begin
            state_d = FETCH;
        end
        if (redirect_valid) begin
            fetchPc_d = redirect_pc;
            retPc_d   = redirect_pc;
            stale_d   = outstanding_d;
            state_d   = ((state_q == FLUSH) || (outstanding_d != '0)) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            fetchPc_q     <= RESET_PC;
            retPc_q       <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetchPc_q     <= fetchPc_d;
            retPc_q       <= retPc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
            started_q     <= 1'b1;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (doPush),
        .pop_i   (doPop),
        .clear_i (redirect_valid),
        .wdata_i (pushEntry),
        .head_o  (headEntry),
        .count_o (fifoCount)
    );

`ifdef IFQ_STALL_COUNT_EN
    logic [15:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else if (!out_valid && (state_q == FETCH) && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

`ifndef SYNTHESIS
    // Memory must never return data that was not requested.
    rvalidWithoutRequest: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outstanding_q != '0));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue with a memory model and
// an in-order instruction-stream scoreboard.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        out_ready;
`ifdef IFQ_STALL_COUNT_EN
    logic [15:0] stall_cnt;
`endif

    instr_fetch_queue #(
        .N_INSTR  (16),
        .ADDR_W   (8),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef IFQ_STALL_COUNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] addr;
    } rsp_t;

    rsp_t       memQ[$];
    logic [7:0] grantLog[$];
    logic [7:0] popLog[$];
    int         cyc, lat, checks, errors, live, reqCount, popCount;
    logic [7:0] expPc, expFetch;
    bit         forceGnt;
    bit         sReq, sValid, sGnt, sRvalid;
    logic [7:0] sAddr, sPc;
    logic [15:0] sInstr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        forceGnt = 1'b0;
        memQ.delete();
        grantLog.delete();
        popLog.delete();
        expPc = 8'h00;
        expFetch = 8'h00;
        live = 0;
        reqCount = 0;
        popCount = 0;
        lat = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req", imem_req, 0);
        checkOutput("reset_addr", imem_addr, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_instr", out_instr, 0);
        checkOutput("reset_pc", out_pc, 0);
`ifdef IFQ_STALL_COUNT_EN
        checkOutput("reset_stall_cnt", stall_cnt, 0);
`endif
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, let memory answer, score, then update the model.
    task automatic applyStimulus(input bit redir, input logic [7:0] rpc, input bit ready, input int gntPct);
        redirect_valid = redir;
        redirect_pc = rpc;
        out_ready = ready;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = 16'h1000 + {8'h00, memQ[0].addr};
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = '0;
        end
        @(negedge clk);
        sGnt = (imem_req || (redir && forceGnt)) && (int'($urandom_range(0, 99)) < gntPct);
        imem_gnt = sGnt;
        sReq = imem_req;
        sAddr = imem_addr;
        sValid = out_valid;
        sPc = out_pc;
        sInstr = out_instr;
        sRvalid = imem_rvalid;
        if (redir) checkOutput("req_in_redirect", sReq, 0);
        if (sReq && sGnt) begin
            checkOutput("fetch_addr", sAddr, expFetch);
            checkOutput("credit", (live < DEPTH), 1);
        end
        if (sValid && ready && !redir) begin
            checkOutput("out_pc", sPc, expPc);
            checkOutput("out_instr", sInstr, 16'h1000 + {8'h00, expPc});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (sRvalid) void'(memQ.pop_front());
        if (sGnt) begin
            memQ.push_back('{due: cyc + lat - 1, addr: sAddr});
            if (!redir) begin
                expFetch++;
                live++;
                reqCount++;
                grantLog.push_back(sAddr);
            end
        end
        if (sValid && ready && !redir) begin
            popLog.push_back(sPc);
            expPc++;
            live--;
            popCount++;
        end
        if (redir) begin
            expPc = rpc;
            expFetch = rpc;
            live = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int firstValid;
        int flushCycles;
        logic [7:0] wrapSeq [3];
        checks = 0;
        errors = 0;
        cyc = 0;

        // Streaming with one-cycle memory latency.
        doReset();
        firstValid = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 100);
            if (sValid && firstValid < 0) firstValid = cyc - 1;
        end
        checkOutput("first_valid_cycle", firstValid, 3);
        checkOutput("stream_pop0", (popLog.size() > 0) ? popLog[0] : 8'hAA, 8'h00);

        // Decoder stalled: credit caps the requests at DEPTH.
        doReset();
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b0, 100);
        checkOutput("stall_req_count", reqCount, DEPTH);
        checkOutput("stall_req_low", sReq, 0);
        checkOutput("stall_valid", sValid, 1);
        checkOutput("stall_head_pc", sPc, 8'h00);
        checkOutput("stall_head_instr", sInstr, 16'h1000);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1, 100);
        checkOutput("resume_count", grantLog.size() > 4, 1);
        if (grantLog.size() > 4) checkOutput("resume_addr", grantLog[4], 8'h04);

        // Redirect with two responses in flight at three-cycle latency.
        doReset();
        lat = 3;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 100);
        applyStimulus(1'b1, 8'h40, 1'b1, 100);
        popLog.delete();
        flushCycles = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 100);
            if (sReq) break;
            flushCycles++;
        end
        checkOutput("flush_cycles", flushCycles, 3);
        checkOutput("flush_first_addr", sAddr, 8'h40);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1, 100);
        checkOutput("flush_first_pop", (popLog.size() > 0) ? popLog[0] : 8'hAA, 8'h40);

        // Redirect colliding with rvalid, a grant and a pop.
        doReset();
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 100);
        forceGnt = 1'b1;
        applyStimulus(1'b1, 8'h80, 1'b1, 100);
        forceGnt = 1'b0;
        checkOutput("collide_setup", {sValid, sRvalid, sGnt}, 3'b111);
        popLog.delete();
        applyStimulus(1'b0, 8'h00, 1'b1, 100);
        checkOutput("collide_count_zero", sValid, 0);
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b1, 100);
        checkOutput("collide_first_pop", (popLog.size() > 0) ? popLog[0] : 8'hAA, 8'h80);

        // PC wrap-around after a redirect near the top of the address space.
        doReset();
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 100);
        applyStimulus(1'b1, 8'hFE, 1'b1, 100);
        grantLog.delete();
        popLog.delete();
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b1, 100);
        wrapSeq[0] = 8'hFE;
        wrapSeq[1] = 8'hFF;
        wrapSeq[2] = 8'h00;
        checkOutput("wrap_len", (grantLog.size() >= 3) && (popLog.size() >= 3), 1);
        if (grantLog.size() >= 3 && popLog.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("wrap_req_addr", grantLog[i], wrapSeq[i]);
                checkOutput("wrap_out_pc", popLog[i], wrapSeq[i]);
            end
        end

`ifdef IFQ_STALL_COUNT_EN
        // Memory idle after reset: every cycle is a stall.
        doReset();
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1, 0);
        checkOutput("stall_cnt_idle", stall_cnt, 16'd10);
`endif

        // Randomized traffic: grants, latency, decoder ready and redirects.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            lat = int'($urandom_range(1, 4));
            applyStimulus(($urandom_range(0, 99) < 3), 8'($urandom), ($urandom_range(0, 99) < 70), 70);
        end
        checkOutput("random_progress", popCount > 200, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Upstream neighbour of the instruction decoder.
- Generates sequential word-addressed fetches to instruction memory and buffers returned 16-bit instructions (with their PCs) in a small FIFO.
- Presents the FIFO head to the decoder through a valid/ready handshake.
- Handles branch redirects: flushes the queue and discards in-flight stale responses.

Parameters:
- N_INSTR, 16, instruction width in bits.
- ADDR_W, 8, instruction-memory word-address width; also the PC width.
- DEPTH, 4, FIFO entries; must be a power of 2 and ≥2.
- RESET_PC, 0, PC fetched first after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  ADDR_W  fetch word address (current PC).
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data returned; responses arrive in order, at least 1 cycle after grant.
- imem_rdata  input  N_INSTR  returned instruction.
- redirect_valid  input  1  branch/jump redirect.
- redirect_pc  input  ADDR_W  redirect target.
- out_valid  output  1  FIFO head valid to decoder.
- out_instr  output  N_INSTR  FIFO head instruction.
- out_pc  output  ADDR_W  PC of FIFO head.
- out_ready  input  1  decoder consumes head.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - Internal: FIFO count, pointers, outstanding and stale counters = 0; state=FETCH.
- States:
  - FETCH: normal fetching.
  - FLUSH: waiting for stale responses to drain.
- Credit rule:
  - imem_req=1 only in FETCH, with no redirect this cycle, and (count + outstanding) < DEPTH.
  - This guarantees the FIFO never overflows.
- Grant:
  - A request with imem_gnt=1 increments outstanding.
  - PC increments by 1, wrapping modulo 2^ADDR_W.
- Response:
  - imem_rvalid decrements outstanding.
  - If stale > 0, the response is dropped and stale decrements.
  - Otherwise {imem_rdata, its PC} is pushed.
  - The response PC comes from a separate return-PC counter, incremented per accepted push.
- Output timing:
  - out_valid = (count != 0); out_instr/out_pc show the head registered in the storage array.
  - rvalid at cycle t makes the data visible at t+1 at the earliest.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop keeps count unchanged.
- Pointers wrap modulo DEPTH.
- out_instr/out_pc hold their last value while out_valid=0.
- Redirect (redirect_valid=1) overrides everything else in that cycle:
  - FIFO cleared (count=0, pointers=0); any pop that cycle is ignored.
  - PC and return-PC set to redirect_pc.
  - stale = outstanding after this cycle's gnt/rvalid accounting: a same-cycle grant counts as stale; a same-cycle rvalid is dropped.
  - Next state is FLUSH if stale != 0, else FETCH.
  - imem_req is forced to 0 in the redirect cycle.
- FLUSH:
  - No requests issued.
  - Go to FETCH in the cycle after stale reaches 0.
  - A redirect during FLUSH reloads the PC and recomputes stale; the block stays in FLUSH.
- rvalid arriving with outstanding=0 is a protocol error: ignored; an assertion fires in simulation.
- Reset mid-operation: immediate return to reset values; in-flight responses after reset are not tracked and must not be produced by memory.

Optional Feature:
- Macro IFQ_STALL_COUNT_EN.
- When defined:
  - Adds output stall_cnt (16 bits, reset 0).
  - Increments on each cycle with out_valid=0 and state=FETCH.
  - Saturates at 0xFFFF.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ifq_pkg holds:
  - state enum ifq_state_t {FETCH, FLUSH};
  - localparam defaults for N_INSTR and ADDR_W;
  - typedef struct ifq_entry_t {instr, pc}.
- One sub-module, ifq_fifo:
  - DEPTH-entry circular buffer of ifq_entry_t;
  - push/pop/clear inputs, count output.
- The top level holds the PC counters, credit logic, stale counter and FSM.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle latency returning 0x1000+addr, out_ready=1 → out sequence (pc 0, 0x1000), (1, 0x1001), (2, 0x1002)…; first out_valid 3 cycles after reset release.
- out_ready=0 with immediate grants → exactly 4 requests issued (addr 0–3); imem_req stays 0; out_valid=1 holding pc 0; releasing ready resumes fetch at addr 4.
- 2 requests outstanding (3-cycle latency), redirect_pc=0x40 → both responses dropped; state FLUSH for 3 cycles; next imem_addr=0x40; first output pc 0x40.
- Redirect in the same cycle as rvalid, gnt and a pop → no output produced from old stream; the granted request is counted stale; count=0 the next cycle.
- PC wrap: redirect_pc=0xFE, ADDR_W=8 → request addresses 0xFE, 0xFF, 0x00; out_pc follows.
- With IFQ_STALL_COUNT_EN, memory idle (gnt=0) for 10 cycles after reset → stall_cnt=10.
